board_vram_avl_writer: RTL and testbench
========================================

// Module: board_vram_avl_writer
// PURPOSE
//  Avalon-MM master that copies one player's 10x20 board (200 cells, 4-bit palette index each) into the text/game VGA
//  slave's VRAM, one 32-bit word per cell. Sits between the game logic's board memory and the VGA slave's
//  AVL_* port, on the same 50 MHz CLK. Also performs a fast CLEAR pass (all cells to colour 0) without reading the board.
// PARAMETERS
//  CELLS     200  cells per player board; index range 0..CELLS-1
//  P0_BASE   0    VRAM word address of player 0 cell 0
//  P1_BASE   200  VRAM word address of player 1 cell 0
//  ADDR_W    12   Avalon address width (word address)
//  COLOR_W   4    palette index width
//  BOARD_AW  8    board memory address width
// PORTS
//  CLK             in   1        system clock, 50 MHz
//  RESET_N         in   1        asynchronous, active-low reset
//  START           in   1        1-cycle request pulse; sampled only in IDLE
//  CLEAR           in   1        qualifies START: 1 = write colour 0 to all cells, no board reads
//  PLAYER          in   1        board select: 0 -> P0_BASE, 1 -> P1_BASE; sampled with START
//  BUSY            out  1        high from cycle after accepted START until DONE
//  DONE            out  1        1-cycle pulse after last write accepted
//  BOARD_RD        out  1        board memory read strobe
//  BOARD_ADDR      out  BOARD_AW cell index (PLAYER is the board memory's MSB select, driven on BOARD_SEL)
//  BOARD_SEL       out  1        latched PLAYER
//  BOARD_DATA      in   COLOR_W  read data, valid the cycle after BOARD_RD (synchronous RAM)
//  AVM_WRITE       out  1        Avalon-MM write
//  AVM_ADDR        out  ADDR_W   Avalon-MM word address
//  AVM_WRITEDATA   out  32       {28'b0, colour}
//  AVM_BYTE_EN     out  4        always 4'b1111
//  AVM_WAITREQUEST in   1        slave stall
// BEHAVIOUR
//  Reset (async, RESET_N=0): state IDLE; BUSY, DONE, BOARD_RD, AVM_WRITE = 0; AVM_ADDR, AVM_WRITEDATA, BOARD_ADDR = 0;
//   cell counter = 0. Reset mid-pass abandons the pass immediately; no DONE is produced.
//  FSM: IDLE -> FETCH -> CAPTURE -> WRITE -> (FETCH | DONE) -> IDLE.
//   IDLE: START=1 latches PLAYER, CLEAR; idx=0; next FETCH (CLEAR=0) or WRITE with colour 0 (CLEAR=1).
//   FETCH: BOARD_RD=1, BOARD_ADDR=idx, 1 cycle.  CAPTURE: register BOARD_DATA into colour reg, 1 cycle.
//   WRITE: AVM_WRITE=1, AVM_ADDR=base+idx, data/addr held stable while AVM_WAITREQUEST=1. Write completes on the
//    first edge with AVM_WRITE=1 and AVM_WAITREQUEST=0. Then idx==CELLS-1 -> DONE, else idx+1 -> FETCH (or WRITE if CLEAR).
//   DONE: DONE=1 for exactly 1 cycle, BUSY drops in the same cycle, next IDLE.
//  Latency with no stalls: 3 cycles/cell normal (600 cycles/pass), 1 cycle/cell CLEAR (200 cycles/pass), +1 DONE.
//  START while BUSY: ignored, not queued. START in the DONE cycle: ignored. CLEAR/PLAYER changes mid-pass: no effect.
//  Address arithmetic: base+idx zero-extended to ADDR_W, no wrap; idx never exceeds CELLS-1.
//  Colour width: BOARD_DATA[COLOR_W-1:0] placed in AVM_WRITEDATA[COLOR_W-1:0]; upper bits 0.
// CONFIGURATION
//  Macro BOARD_VRAM_SKIP_UNCHANGED_EN.
//   Defined: shadow store 2 x CELLS x COLOR_W plus one valid bit per player. In CAPTURE, if shadow valid and
//    BOARD_DATA == shadow[PLAYER][idx], WRITE is skipped (next FETCH or DONE directly). Every completed write updates
//    the shadow. Full pass sets the player's valid bit; CLEAR pass writes all cells and sets shadow to 0, valid=1.
//    Reset clears both valid bits (shadow contents don't care). An all-skipped pass still produces DONE.
//   Undefined: no shadow; every cell written every pass.
// STRUCTURE
//  Package board_vram_pkg: state enum typedef (IDLE, FETCH, CAPTURE, WRITE, DONE), CELLS, P0_BASE, P1_BASE defaults,
//   BYTE_EN_ALL = 4'b1111. The VGA slave's VRAM base constants come from the same package.
//  One sub-module when the macro is defined: board_shadow_ram (1 write port, 1 combinational read port).
// TESTING
//  1 No stall, PLAYER=0, board cell i = i%16: 200 writes, addr 0..199, data i%16, DONE at cycle 601 after START.
//  2 PLAYER=1, WAITREQUEST held 3 cycles on every write: addr 200..399, addr/data stable during stall, 200 writes total.
//  3 CLEAR=1, PLAYER=1: no BOARD_RD, 200 writes of 32'h0 to 200..399 on consecutive cycles, DONE at cycle 201.
//  4 START pulsed mid-pass and in DONE cycle: exactly one pass, one DONE; RESET_N low at cell 57: AVM_WRITE=0 at once, no DONE.
//  5 Macro defined, two passes, board change only at cells 5 and 199: second pass issues exactly 2 writes (addr 5, 199).
//  6 Macro defined, reset after a pass, rerun same board: all 200 writes issued (shadow invalid).

Source files
------------

// File: rtl/board_vram_pkg.sv
// Shared constants and types for the board-to-VRAM Avalon writer and the VGA slave VRAM map.
package board_vram_pkg;

  localparam int unsigned CELLS     = 200;
  localparam int unsigned P0_BASE   = 0;
  localparam int unsigned P1_BASE   = 200;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned COLOR_W   = 4;
  localparam int unsigned BOARD_AW  = 8;
  localparam int unsigned SHADOW_AW = 9;

  localparam logic [3:0] BYTE_EN_ALL = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StWrite,
    StDone
  } state_e;

  // Player 1 cells live directly after player 0 cells in the shadow store.
  function automatic logic [SHADOW_AW-1:0] shadow_addr(input logic player,
                                                       input logic [BOARD_AW-1:0] idx);
    return (player ? SHADOW_AW'(CELLS) : '0) + SHADOW_AW'(idx);
  endfunction

endpackage

// File: rtl/board_vram_avl_writer_if.sv
// Avalon-MM write-only bus between the board writer (master) and the VGA slave VRAM port.
interface board_vram_avl_writer_if
  import board_vram_pkg::*;
;
  logic              AVM_WRITE;
  logic [ADDR_W-1:0] AVM_ADDR;
  logic [31:0]       AVM_WRITEDATA;
  logic [3:0]        AVM_BYTE_EN;
  logic              AVM_WAITREQUEST;

  modport master (
    output AVM_WRITE, AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN,
    input  AVM_WAITREQUEST
  );

  modport slave (
    input  AVM_WRITE, AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN,
    output AVM_WAITREQUEST
  );
endinterface

// File: rtl/board_shadow_ram.sv
// Shadow copy of the last colour written per cell for both players (1 write, 1 async read port).
// Only built when BOARD_VRAM_SKIP_UNCHANGED_EN is defined.
`ifdef BOARD_VRAM_SKIP_UNCHANGED_EN
module board_shadow_ram
  import board_vram_pkg::*;
(
  input  logic                 CLK,
  input  logic                 we,
  input  logic [SHADOW_AW-1:0] wr_addr,
  input  logic [COLOR_W-1:0]   wr_data,
  input  logic [SHADOW_AW-1:0] rd_addr,
  output logic [COLOR_W-1:0]   rd_data
);
  logic [COLOR_W-1:0] mem [2*CELLS];

  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule
`endif

// File: rtl/board_vram_avl_writer.sv
// Copies one player's 10x20 board into VGA VRAM over Avalon-MM, or clears it to colour 0.
// Define BOARD_VRAM_SKIP_UNCHANGED_EN to skip writes of cells whose colour is already in VRAM.
module board_vram_avl_writer
  import board_vram_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                START,
  input  logic                CLEAR,
  input  logic                PLAYER,
  output logic                BUSY,
  output logic                DONE,
  output logic                BOARD_RD,
  output logic [BOARD_AW-1:0] BOARD_ADDR,
  output logic                BOARD_SEL,
  input  logic [COLOR_W-1:0]  BOARD_DATA,
  board_vram_avl_writer_if.master avm
);
  state_e              state_q, state_d;
  logic [BOARD_AW-1:0] idx_q, idx_d;
  logic [COLOR_W-1:0]  colour_q, colour_d;
  logic                player_q, player_d;
  logic                clear_q, clear_d;
  logic                last_cell, wr_done, skip;

  assign last_cell = (idx_q == BOARD_AW'(CELLS - 1));
  assign wr_done   = (state_q == StWrite) && !avm.AVM_WAITREQUEST;

`ifdef BOARD_VRAM_SKIP_UNCHANGED_EN
  logic [1:0]         valid_q, valid_d;
  logic [COLOR_W-1:0] shadow_rd;

  board_shadow_ram u_shadow (
    .CLK     (CLK),
    .we      (wr_done),
    .wr_addr (shadow_addr(player_q, idx_q)),
    .wr_data (colour_q),
    .rd_addr (shadow_addr(player_q, idx_q)),
    .rd_data (shadow_rd)
  );

  assign skip = valid_q[player_q] && (BOARD_DATA == shadow_rd);

  // A pass only reaches DONE after every cell was written or matched, so the shadow is complete.
  always_comb begin
    valid_d = valid_q;
    if (state_q == StDone) valid_d[player_q] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) valid_q <= '0;
    else          valid_q <= valid_d;
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      colour_q <= '0;
      player_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      colour_q <= colour_d;
      player_q <= player_d;
      clear_q  <= clear_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    colour_d = colour_q;
    player_d = player_q;
    clear_d  = clear_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          player_d = PLAYER;
          clear_d  = CLEAR;
          idx_d    = '0;
          colour_d = '0;
          state_d  = CLEAR ? StWrite : StFetch;
        end
      end
      StFetch:   state_d = StCapture;
      StCapture: begin
        colour_d = BOARD_DATA;
        if (!skip)          state_d = StWrite;
        else if (last_cell) state_d = StDone;
        else begin
          idx_d   = idx_q + BOARD_AW'(1);
          state_d = StFetch;
        end
      end
      StWrite: begin
        if (!avm.AVM_WAITREQUEST) begin
          if (last_cell) state_d = StDone;
          else begin
            idx_d   = idx_q + BOARD_AW'(1);
            state_d = clear_q ? StWrite : StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign BUSY       = (state_q != StIdle) && (state_q != StDone);
  assign DONE       = (state_q == StDone);
  assign BOARD_RD   = (state_q == StFetch);
  assign BOARD_ADDR = idx_q;
  assign BOARD_SEL  = player_q;

  assign avm.AVM_WRITE     = (state_q == StWrite);
  assign avm.AVM_ADDR      = (player_q ? ADDR_W'(P1_BASE) : ADDR_W'(P0_BASE)) + ADDR_W'(idx_q);
  assign avm.AVM_WRITEDATA = {{(32 - COLOR_W){1'b0}}, colour_q};
  assign avm.AVM_BYTE_EN   = BYTE_EN_ALL;
endmodule

// File: tb/tb_board_vram_avl_writer.sv
// Directed bench for board_vram_avl_writer: board RAM and Avalon slave models plus a write logger.
module tb_board_vram_avl_writer;
  import board_vram_pkg::*;

  logic                CLK = 1'b0;
  logic                RESET_N = 1'b1;
  logic                START = 1'b0;
  logic                CLEAR = 1'b0;
  logic                PLAYER = 1'b0;
  logic                BUSY, DONE, BOARD_RD, BOARD_SEL;
  logic [BOARD_AW-1:0] BOARD_ADDR;
  logic [COLOR_W-1:0]  BOARD_DATA;

  board_vram_avl_writer_if avm ();

  board_vram_avl_writer dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .CLEAR      (CLEAR),
    .PLAYER     (PLAYER),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .BOARD_RD   (BOARD_RD),
    .BOARD_ADDR (BOARD_ADDR),
    .BOARD_SEL  (BOARD_SEL),
    .BOARD_DATA (BOARD_DATA),
    .avm        (avm)
  );

  logic [3:0]        board [2][CELLS];
  int                stall_len = 0;
  int                stall_cnt = 0;
  int                cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0;
  int                stall_cycles = 0, stall_viol = 0;
  int                log_addr [4096];
  logic [31:0]       log_data [4096];
  int                log_cyc  [4096];
  logic              held_v = 1'b0;
  logic [ADDR_W-1:0] held_addr = '0;
  logic [31:0]       held_data = '0;
  int                vecs = 0, errs = 0;

  always #10 CLK = ~CLK;

  // Slave stalls the first stall_len cycles of every write.
  assign avm.AVM_WAITREQUEST = avm.AVM_WRITE && (stall_cnt < stall_len);

  always @(posedge CLK) begin
    if (BOARD_RD) BOARD_DATA <= board[BOARD_SEL][BOARD_ADDR];
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (BOARD_RD) rd_cnt <= rd_cnt + 1;
    if (DONE) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!RESET_N) begin
      stall_cnt <= 0;
      held_v    <= 1'b0;
    end else if (avm.AVM_WRITE) begin
      if (held_v && (avm.AVM_ADDR !== held_addr || avm.AVM_WRITEDATA !== held_data))
        stall_viol <= stall_viol + 1;
      if (avm.AVM_WAITREQUEST) begin
        stall_cnt    <= stall_cnt + 1;
        stall_cycles <= stall_cycles + 1;
        held_v       <= 1'b1;
        held_addr    <= avm.AVM_ADDR;
        held_data    <= avm.AVM_WRITEDATA;
      end else begin
        stall_cnt <= 0;
        held_v    <= 1'b0;
        if (wr_cnt < 4096) begin
          log_addr[wr_cnt] <= int'(avm.AVM_ADDR);
          log_data[wr_cnt] <= avm.AVM_WRITEDATA;
          log_cyc[wr_cnt]  <= cyc;
        end
        wr_cnt <= wr_cnt + 1;
      end
    end else begin
      held_v <= 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  // s = index of the posedge that samples START.
  task automatic start_pass(input logic clr, input logic plr, output int s);
    @(negedge CLK);
    CLEAR  = clr;
    PLAYER = plr;
    START  = 1'b1;
    s      = cyc;
    @(negedge CLK);
    START  = 1'b0;
    CLEAR  = ~clr;
    PLAYER = ~plr;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (done_cnt == d0) begin
      vecs++;
      errs++;
      $display("FAIL %s_done_timeout: actual no DONE in %0d cycles, required DONE", name, budget);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    vecs++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errs++;
      $display("FAIL reset_busy_done: actual %b%b required 00", BUSY, DONE);
    end
    vecs++;
    if (BOARD_RD !== 1'b0 || avm.AVM_WRITE !== 1'b0) begin
      errs++;
      $display("FAIL reset_strobes: actual rd=%b wr=%b required 0 0", BOARD_RD, avm.AVM_WRITE);
    end
    vecs++;
    if (avm.AVM_ADDR !== '0 || avm.AVM_WRITEDATA !== 32'h0 || BOARD_ADDR !== '0) begin
      errs++;
      $display("FAIL reset_addr_data: actual %h %h %h required 0 0 0",
               avm.AVM_ADDR, avm.AVM_WRITEDATA, BOARD_ADDR);
    end
    vecs++;
    if (avm.AVM_BYTE_EN !== 4'b1111) begin
      errs++;
      $display("FAIL reset_byte_en: actual %b required 1111", avm.AVM_BYTE_EN);
    end
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_normal();
    int s, w0, r0, d0, bad;
    for (int i = 0; i < int'(CELLS); i++) board[0][i] = 4'(i % 16);
    stall_len = 0;
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    start_pass(1'b0, 1'b0, s);
    vecs++;
    if (BUSY !== 1'b1) begin
      errs++;
      $display("FAIL t1_busy: actual %b required 1", BUSY);
    end
    wait_done(d0, 2000, "t1");
    vecs++;
    if (wr_cnt - w0 != 200) begin
      errs++;
      $display("FAIL t1_writes: actual %0d required 200", wr_cnt - w0);
    end
    bad = -1;
    for (int i = 0; i < int'(CELLS); i++)
      if (bad < 0 && (log_addr[w0+i] != i || log_data[w0+i] !== 32'(i % 16))) bad = i;
    vecs++;
    if (bad >= 0) begin
      errs++;
      $display("FAIL t1_addr_data: cell %0d actual %0d/%h required %0d/%h",
               bad, log_addr[w0+bad], log_data[w0+bad], bad, 32'(bad % 16));
    end
    vecs++;
    if (done_cyc - s != 601) begin
      errs++;
      $display("FAIL t1_latency: actual %0d required 601", done_cyc - s);
    end
    vecs++;
    if (rd_cnt - r0 != 200 || BUSY !== 1'b0) begin
      errs++;
      $display("FAIL t1_reads_busy: actual %0d/%b required 200/0", rd_cnt - r0, BUSY);
    end
  endtask

  task automatic test_stall();
    int s, w0, st0, v0, d0, bad;
    for (int i = 0; i < int'(CELLS); i++) board[1][i] = 4'((i * 7 + 3) % 16);
    stall_len = 3;
    w0 = wr_cnt; st0 = stall_cycles; v0 = stall_viol; d0 = done_cnt;
    start_pass(1'b0, 1'b1, s);
    wait_done(d0, 3000, "t2");
    stall_len = 0;
    vecs++;
    if (wr_cnt - w0 != 200) begin
      errs++;
      $display("FAIL t2_writes: actual %0d required 200", wr_cnt - w0);
    end
    bad = -1;
    for (int i = 0; i < int'(CELLS); i++)
      if (bad < 0 && (log_addr[w0+i] != 200 + i || log_data[w0+i] !== 32'((i * 7 + 3) % 16)))
        bad = i;
    vecs++;
    if (bad >= 0) begin
      errs++;
      $display("FAIL t2_addr_data: cell %0d actual %0d/%h required %0d/%h",
               bad, log_addr[w0+bad], log_data[w0+bad], 200 + bad, 32'((bad * 7 + 3) % 16));
    end
    vecs++;
    if (stall_cycles - st0 != 600 || stall_viol != v0) begin
      errs++;
      $display("FAIL t2_stall: actual stalls=%0d unstable=%0d required 600 0",
               stall_cycles - st0, stall_viol - v0);
    end
    vecs++;
    if (done_cyc - s != 1201) begin
      errs++;
      $display("FAIL t2_latency: actual %0d required 1201", done_cyc - s);
    end
  endtask

  task automatic test_clear();
    int s, w0, r0, d0, bad;
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    start_pass(1'b1, 1'b1, s);
    wait_done(d0, 1000, "t3");
    vecs++;
    if (rd_cnt != r0 || wr_cnt - w0 != 200) begin
      errs++;
      $display("FAIL t3_counts: actual rd=%0d wr=%0d required 0 200", rd_cnt - r0, wr_cnt - w0);
    end
    bad = -1;
    for (int i = 0; i < int'(CELLS); i++)
      if (bad < 0 && (log_addr[w0+i] != 200 + i || log_data[w0+i] !== 32'h0 ||
                      log_cyc[w0+i] != s + 1 + i)) bad = i;
    vecs++;
    if (bad >= 0) begin
      errs++;
      $display("FAIL t3_writes: cell %0d actual %0d/%h@%0d required %0d/0@%0d",
               bad, log_addr[w0+bad], log_data[w0+bad], log_cyc[w0+bad] - s, 200 + bad, bad + 1);
    end
    vecs++;
    if (done_cyc - s != 201) begin
      errs++;
      $display("FAIL t3_latency: actual %0d required 201", done_cyc - s);
    end
  endtask

  task automatic test_ignore_and_abort();
    int s, w0, d0, bad, n;
    do_reset();
    w0 = wr_cnt; d0 = done_cnt;
    start_pass(1'b0, 1'b0, s);
    repeat (100) @(negedge CLK);
    START = 1'b1; PLAYER = 1'b1; CLEAR = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    while (cyc < s + 601) @(negedge CLK);
    vecs++;
    if (DONE !== 1'b1) begin
      errs++;
      $display("FAIL t4_done_cycle: actual %b required 1", DONE);
    end
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0; PLAYER = 1'b0; CLEAR = 1'b0;
    repeat (20) @(negedge CLK);
    vecs++;
    if (done_cnt - d0 != 1 || wr_cnt - w0 != 200 || BUSY !== 1'b0) begin
      errs++;
      $display("FAIL t4_single_pass: actual done=%0d wr=%0d busy=%b required 1 200 0",
               done_cnt - d0, wr_cnt - w0, BUSY);
    end
    bad = -1;
    for (int i = 0; i < int'(CELLS); i++)
      if (bad < 0 && (log_addr[w0+i] != i || log_data[w0+i] !== 32'(i % 16))) bad = i;
    vecs++;
    if (bad >= 0) begin
      errs++;
      $display("FAIL t4_addr_data: cell %0d actual %0d/%h required %0d/%h",
               bad, log_addr[w0+bad], log_data[w0+bad], bad, 32'(bad % 16));
    end

    do_reset();
    w0 = wr_cnt; d0 = done_cnt;
    start_pass(1'b0, 1'b0, s);
    n = 0;
    while (!(avm.AVM_WRITE === 1'b1 && avm.AVM_ADDR == ADDR_W'(57)) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    vecs++;
    if (n >= 1000) begin
      errs++;
      $display("FAIL t4_reach_57: actual not reached required write to 57");
    end
    RESET_N = 1'b0;
    #1;
    vecs++;
    if (avm.AVM_WRITE !== 1'b0 || BUSY !== 1'b0) begin
      errs++;
      $display("FAIL t4_abort: actual wr=%b busy=%b required 0 0", avm.AVM_WRITE, BUSY);
    end
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (700) @(negedge CLK);
    vecs++;
    if (done_cnt != d0 || wr_cnt - w0 != 57) begin
      errs++;
      $display("FAIL t4_no_done: actual done=%0d wr=%0d required 0 57", done_cnt - d0, wr_cnt - w0);
    end
  endtask

`ifdef BOARD_VRAM_SKIP_UNCHANGED_EN
  task automatic test_skip();
    int s, w0, d0;
    do_reset();
    for (int i = 0; i < int'(CELLS); i++) board[0][i] = 4'(i % 16);
    d0 = done_cnt; w0 = wr_cnt;
    start_pass(1'b0, 1'b0, s);
    wait_done(d0, 2000, "t5a");
    vecs++;
    if (wr_cnt - w0 != 200) begin
      errs++;
      $display("FAIL t5_first_pass: actual %0d required 200", wr_cnt - w0);
    end
    board[0][5]   = 4'hA;
    board[0][199] = 4'h3;
    d0 = done_cnt; w0 = wr_cnt;
    start_pass(1'b0, 1'b0, s);
    wait_done(d0, 2000, "t5b");
    vecs++;
    if (wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin
      errs++;
      $display("FAIL t5_skip_count: actual wr=%0d done=%0d required 2 1", wr_cnt - w0, done_cnt - d0);
    end
    vecs++;
    if (log_addr[w0] != 5 || log_data[w0] !== 32'hA ||
        log_addr[w0+1] != 199 || log_data[w0+1] !== 32'h3) begin
      errs++;
      $display("FAIL t5_skip_writes: actual %0d/%h %0d/%h required 5/a 199/3",
               log_addr[w0], log_data[w0], log_addr[w0+1], log_data[w0+1]);
    end
  endtask

  task automatic test_shadow_reset();
    int s, w0, d0;
    do_reset();
    d0 = done_cnt; w0 = wr_cnt;
    start_pass(1'b0, 1'b0, s);
    wait_done(d0, 2000, "t6");
    vecs++;
    if (wr_cnt - w0 != 200) begin
      errs++;
      $display("FAIL t6_rerun: actual %0d required 200", wr_cnt - w0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_clear();
    test_ignore_and_abort();
`ifdef BOARD_VRAM_SKIP_UNCHANGED_EN
    test_skip();
    test_shadow_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
